// File: rtl/sram_like_arbiter_pkg.sv
// sram_like_arbiter_pkg: shared source IDs and size encodings for the SRAM-like arbiter.
package sram_like_arbiter_pkg;
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// arb_id_fifo: small in-order FIFO remembering which master owns each outstanding request.
module arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int AW = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = din;
    wp_d = push ? wp_q + 1'b1 : wp_q;
    rp_d = pop ? rp_q + 1'b1 : rp_q;
    count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      count_q <= count_d;
    end
  end
  assign dout = mem_q[rp_q];
  assign count = count_q;
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges instruction and data SRAM-like masters onto one slave port,
// data wins conflicts, responses routed back in order via a source-ID queue.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int OT_DEPTH = 4,
  parameter int OT_AW = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        proto_err
);
  logic grant, gnt_d, push, pop, full, empty, head, stall;
  logic [OT_AW:0] count;
  logic lock_q, lock_d, lock_src_q, lock_src_d, proto_err_q, proto_err_d;
  arb_id_fifo #(.DEPTH(OT_DEPTH), .AW(OT_AW), .W(1)) u_id_fifo (
    .clk(clk), .reset(reset), .push(push), .din(grant), .pop(pop),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  // A stalled request keeps its grant so mem_* fields never change before addr_ok.
  always_comb begin
    grant = lock_q ? lock_src_q : (data_req ? SRC_DATA : SRC_INST);
    gnt_d = grant == SRC_DATA;
    mem_req = (gnt_d ? data_req : inst_req) & ~full & ~reset;
    mem_wr = gnt_d ? data_wr : inst_wr;
    mem_size = gnt_d ? data_size : inst_size;
    mem_wstrb = gnt_d ? data_wstrb : inst_wstrb;
    mem_addr = gnt_d ? data_addr : inst_addr;
    mem_wdata = gnt_d ? data_wdata : inst_wdata;
    push = mem_req & mem_addr_ok;
    inst_addr_ok = push & ~gnt_d;
    data_addr_ok = push & gnt_d;
    pop = mem_data_ok & ~empty & ~reset;
    inst_data_ok = pop & (head == SRC_INST);
    data_data_ok = pop & (head == SRC_DATA);
    stall = mem_req & ~mem_addr_ok;
    lock_d = stall ? 1'b1 : (mem_addr_ok ? 1'b0 : lock_q);
    lock_src_d = stall ? grant : lock_src_q;
    proto_err_d = proto_err_q | (mem_data_ok & (count == '0));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q <= 1'b0;
      lock_src_q <= SRC_INST;
      proto_err_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
      lock_src_q <= lock_src_d;
      proto_err_q <= proto_err_d;
    end
  end
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;
  assign proto_err = proto_err_q;
endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
Merges the CPU core's instruction and data SRAM-like master ports onto one SRAM-like slave port toward the memory/bus bridge. It sits directly downstream of the CPU top: the instruction-fetch and load/store requests enter here, and one request stream leaves for memory. Data requests win on a same-cycle conflict. A small in-order ID queue routes each returned data_ok/rdata back to the master that issued the request.

Parameters:
OT_DEPTH, 4, maximum outstanding accepted-but-unreturned requests; power of 2, at least 2
OT_AW, 2, log2(OT_DEPTH); counter is OT_AW+1 bits

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
inst_req  in  1  instruction master request valid
inst_wr  in  1  write (always 0 in normal use, still forwarded)
inst_size  in  2  0=byte 1=half 2=word
inst_wstrb  in  4  byte strobes
inst_addr  in  32  request address
inst_wdata  in  32  write data
inst_addr_ok  out  1  instruction request accepted this cycle
inst_data_ok  out  1  instruction response returned this cycle
inst_rdata  out  32  instruction read data
data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data master request, same meaning as inst_*
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  data response returned
data_rdata  out  32  data read data
mem_req  out  1  slave request valid
mem_wr  out  1  slave write
mem_size  out  2  slave size
mem_wstrb  out  4  slave strobes
mem_addr  out  32  slave address
mem_wdata  out  32  slave write data
mem_addr_ok  in  1  slave accepted request
mem_data_ok  in  1  slave response valid
mem_rdata  in  32  slave read data
proto_err  out  1  sticky: mem_data_ok received with empty queue

Behaviour:
- Reset: ID queue empty, count=0, lock=0, proto_err=0. All *_addr_ok, *_data_ok and mem_req are 0 while reset=1. rdata outputs pass through mem_rdata unchanged.
- Handshake: a request transfers in a cycle where req=1 and addr_ok=1. The response transfers when data_ok=1. Masters hold their request fields stable until addr_ok.
- Grant, combinational: if lock=1, grant=lock_src. Otherwise grant=DATA when data_req=1, else INST when inst_req=1.
- lock: set when mem_req=1 and mem_addr_ok=0 (lock_src=grant). Cleared on mem_addr_ok. The grant never switches mid-request.
- mem_* request fields are muxed from the granted master, with 0 added to the path.
- mem_req = granted master's req AND NOT full AND NOT reset.
- Granted master's addr_ok = mem_addr_ok AND mem_req. The other master's addr_ok = 0.
- ID queue: 1-bit source FIFO, OT_DEPTH entries, rd/wr pointers wrap modulo OT_DEPTH.
  - Push on mem_req and mem_addr_ok.
  - Pop on mem_data_ok with count>0.
  - Push and pop in the same cycle leave count unchanged; legal at any count below full.
  - Full (count=OT_DEPTH) blocks mem_req, so there is no push when full. A pop at full frees the slot the next cycle.
- Response routing: head=0 raises inst_data_ok=mem_data_ok; head=1 raises data_data_ok. Responses return strictly in order.
- mem_data_ok with empty queue: no *_data_ok, no pointer change, proto_err set until reset.
- Writes occupy a queue slot like reads; their data_ok is routed the same way.
- Reset mid-operation clears the queue and lock. Responses still in flight afterwards are treated as protocol errors.
- Latency: 0 cycles combinational on both request and response paths. Only queue, count, lock and proto_err are registered.

Decomposition:
- Shared package: SRC_INST=1'b0, SRC_DATA=1'b1; SIZE_BYTE/HALF/WORD encodings.
- One sub-module: arb_id_fifo, parameterised by depth and width (width=1 here). Ports: push, din, pop, dout, full, empty, count.

Test Plan:
- Both masters request word reads in the same cycle, mem_addr_ok=1: data_addr_ok=1 and inst_addr_ok=0. Next cycle inst is granted. Return rdata 0x11111111 then 0x22222222: data_data_ok sees 0x11111111 first, then inst_data_ok sees 0x22222222.
- inst_req at 0x1C000000 held with mem_addr_ok=0 for 3 cycles, data_req raised in cycle 2: mem_addr stays 0x1C000000 and data is not granted until the inst addr_ok.
- 4 inst reads accepted with no response: count=4, mem_req=0 despite inst_req=1. One mem_data_ok: inst_data_ok=1, and mem_req=1 again the next cycle.
- Queue at count=2; in one cycle a data store is accepted (wstrb=4'b0011, size=1) and mem_data_ok=1: the head source is routed, count stays 2, and the strobes are forwarded unchanged.
- mem_data_ok pulsed with empty queue: both data_ok=0 and proto_err=1, held until reset.
- Reset asserted with 3 outstanding: next cycle count=0, lock=0, mem_req=0, proto_err=0. The following mem_data_ok sets proto_err.
